// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small write FIFO.
// Bytes queued with a one-cycle strobe are sent LSB first. The next frame's
// start bit follows the previous stop bit with no idle gap.
`timescale 1ns/1ps

module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_ovf,
  output logic       txd
);

  // Bit period in clock cycles, rounded to the nearest integer.
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW  = PW + 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [NW-1:0] DEPTH_C  = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Pointer advance; the pointer width matches the power-of-two depth,
  // so the addition wraps naturally.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    ptr_inc = ptr + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [NW-1:0] count_r;
  logic [NW-1:0] count_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [7:0]    head_s;

  // Transmit engine
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] baud_r;
  logic [CW-1:0] baud_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic          txd_r;
  logic          txd_s;
  logic          expire_s;

  // Registered status outputs
  logic          tx_full_r;
  logic          tx_busy_r;
  logic          tx_ovf_r;

  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == {NW{1'b0}});
  assign push_s   = tx_wr & ~full_s;
  assign head_s   = mem_r[rd_ptr_r];
  assign expire_s = (baud_r == DIV_LAST);

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + {{(NW-1){1'b0}}, 1'b1};
      2'b01:   count_s = count_r - {{(NW-1){1'b0}}, 1'b1};
      default: count_s = count_r;
    endcase
  end

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_50mhz) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {NW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_s;
    end
  end

  // Frame sequencer: next state, baud timing, shift register and line level.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_s = {CW{1'b0}};
        bit_s  = 3'd0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          txd_s   = 1'b0;
          state_s = ST_START;
        end else begin
          txd_s   = 1'b1;
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (expire_s) begin
          baud_s  = {CW{1'b0}};
          bit_s   = 3'd0;
          txd_s   = shift_r[0];
          state_s = ST_DATA;
        end else begin
          baud_s  = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (expire_s) begin
          baud_s = {CW{1'b0}};
          if (bit_r == 3'd7) begin
            txd_s   = 1'b1;
            state_s = ST_STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            txd_s   = shift_r[1];
          end
        end else begin
          baud_s = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (expire_s) begin
          baud_s = {CW{1'b0}};
          if (!empty_s) begin
            // Chain straight into the next start bit.
            pop_s   = 1'b1;
            shift_s = head_s;
            txd_s   = 1'b0;
            state_s = ST_START;
          end else begin
            txd_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          baud_s = baud_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        baud_s  = {CW{1'b0}};
        bit_s   = 3'd0;
        txd_s   = 1'b1;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset forces the line idle high immediately.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      baud_r  <= {CW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      txd_r   <= txd_s;
    end
  end

  // Status flags registered from the post-edge count and state.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      tx_full_r <= 1'b0;
      tx_busy_r <= 1'b0;
      tx_ovf_r  <= 1'b0;
    end else begin
      tx_full_r <= (count_s == DEPTH_C);
      tx_busy_r <= (state_s != ST_IDLE) || (count_s != {NW{1'b0}});
      tx_ovf_r  <= tx_wr & full_s;
    end
  end

  assign tx_full = tx_full_r;
  assign tx_busy = tx_busy_r;
  assign tx_ovf  = tx_ovf_r;
  assign txd     = txd_r;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table-driven single-byte frames plus hand-written
// burst, overflow, full-with-pop and mid-frame reset sequences. A line
// monitor decodes every frame and compares it against a scoreboard queue.
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_full;
  logic       tx_busy;
  logic       tx_ovf;
  logic       txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int mon_starts[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;      // bit i = mid-bit sample i (start, d0..d7, stop)
    int         busy_cycles;
  } vec_t;
  vec_t vecs[4];

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_50mhz(clk),
    .reset    (rst_n),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_busy  (tx_busy),
    .tx_ovf   (tx_ovf),
    .txd      (txd)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, tx_busy, 0);
    repeat (5) @(negedge clk);
  endtask

  // Line monitor: finds start bits, samples mid-bit, checks against queue.
  initial begin : monitor
    int pos;
    logic [7:0] sh;
    logic act;
    logic [7:0] e;
    act = 1'b0;
    pos = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
      end else if (!act) begin
        if (txd === 1'b0) begin
          act = 1'b1;
          pos = 0;
          mon_starts.push_back(cyc);
        end
      end else begin
        pos++;
        if (pos == 5) begin
          check("mon_start_bit", txd, 0);
        end else if (pos >= 15 && pos <= 85 && (pos % 10) == 5) begin
          sh[(pos - 15) / 10] = txd;
        end else if (pos == 95) begin
          check("mon_stop_bit", txd, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected_frame: got byte %0h, expected no frame", sh);
          end else begin
            e = exp_q.pop_front();
            check("mon_byte", sh, e);
          end
        end
        if (pos == 99) act = 1'b0;
      end
    end
  end

  initial begin : stim
    int s0;
    int bad;

    vecs[0] = '{data: 8'hA5, bits: 10'b1101001010, busy_cycles: 101};
    vecs[1] = '{data: 8'h00, bits: 10'b1000000000, busy_cycles: 101};
    vecs[2] = '{data: 8'hFF, bits: 10'b1111111110, busy_cycles: 101};
    vecs[3] = '{data: 8'h3C, bits: 10'b1001111000, busy_cycles: 101};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd_during", txd, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_full", tx_full, 0);
    check("rst_ovf", tx_ovf, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("idle_txd_hold", bad, 0);

    // Single-byte frames from the table
    for (int v = 0; v < 4; v++) begin
      int busy_n;
      logic [9:0] got;
      @(negedge clk);
      tx_data = vecs[v].data;
      tx_wr = 1'b1;
      exp_q.push_back(vecs[v].data);
      @(posedge clk);
      #1 tx_wr = 1'b0;
      busy_n = 0;
      got = 10'd0;
      for (int j = 0; j < 120; j++) begin
        @(negedge clk);
        if (tx_busy === 1'b1) busy_n++;
        if (j == 0) check("txd_before_pop", txd, 1);
        if (j == 1) check("txd_fall_after_pop", txd, 0);
        if ((j % 10) == 6 && j <= 96) got[(j - 6) / 10] = txd;
      end
      check("frame_bits", got, vecs[v].bits);
      check("busy_cycles", busy_n, vecs[v].busy_cycles);
      check("busy_low_after", tx_busy, 0);
    end

    // Burst of three contiguous frames
    s0 = mon_starts.size();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tx_data = i[7:0];
      tx_wr = 1'b1;
      exp_q.push_back(i[7:0]);
    end
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle("burst", 400);
    check("burst_frames", mon_starts.size() - s0, 3);
    if (mon_starts.size() >= s0 + 3) begin
      check("burst_gap_1", mon_starts[s0+1] - mon_starts[s0], 100);
      check("burst_gap_2", mon_starts[s0+2] - mon_starts[s0+1], 100);
    end

    // Overflow: six writes from idle, the sixth is dropped
    s0 = mon_starts.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) check("ovf_not_full_before_5th", tx_full, 0);
      if (i == 5) begin
        check("ovf_full_after_5th", tx_full, 1);
        check("ovf_no_pulse_yet", tx_ovf, 0);
      end
      tx_data = 8'h10 + i[7:0];
      tx_wr = 1'b1;
      if (i < 5) exp_q.push_back(8'h10 + i[7:0]);
    end
    @(negedge clk);
    tx_wr = 1'b0;
    check("ovf_pulse", tx_ovf, 1);
    check("ovf_still_full", tx_full, 1);
    @(negedge clk);
    check("ovf_single_cycle", tx_ovf, 0);
    wait_idle("ovf", 700);
    check("ovf_frames", mon_starts.size() - s0, 5);

    // Full FIFO with a write at the same edge as the stop-to-start pop
    s0 = mon_starts.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_data = 8'h40 + i[7:0];
      tx_wr = 1'b1;
      exp_q.push_back(8'h40 + i[7:0]);
    end
    @(negedge clk);
    tx_wr = 1'b0;
    check("fp_setup_full", tx_full, 1);
    repeat (96) @(negedge clk);
    check("fp_stop_before_pop", txd, 1);
    tx_data = 8'hEE;
    tx_wr = 1'b1;
    @(negedge clk);
    check("fp_ovf_pulse", tx_ovf, 1);
    check("fp_count3_not_full", tx_full, 0);
    check("fp_contiguous_start", txd, 0);
    tx_data = 8'h77;
    tx_wr = 1'b1;
    exp_q.push_back(8'h77);
    @(negedge clk);
    tx_wr = 1'b0;
    check("fp_refill_full", tx_full, 1);
    check("fp_ovf_cleared", tx_ovf, 0);
    wait_idle("fp", 900);
    check("fp_frames", mon_starts.size() - s0, 6);

    // Reset during data bit 3 of 0xFF with two bytes queued
    s0 = mon_starts.size();
    @(negedge clk);
    tx_data = 8'hFF;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (44) @(negedge clk);
    check("rmf_busy_before", tx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmf_txd_async", txd, 1);
    check("rmf_busy", tx_busy, 0);
    check("rmf_full", tx_full, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("rmf_quiet_after", bad, 0);
    check("rmf_frames", mon_starts.size() - s0, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
